// File: rtl/axi4_slave_pkg.sv
// Shared types and constants for the AXI4 memory-mapped slave.
// Covers the B-channel response codes, the write FSM states and the 4KB burst boundary.
package axi4_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wstate_t;

    localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// INCR burst address generator: tracks the current byte address and beat count,
// and derives the byte-lane mask and last-beat flag from the latched AW fields.
module axi4_burst_addr_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic                    step,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [7:0]              len,
    input  logic [2:0]              size,
    output logic [ADDR_WIDTH:0]     cur_addr,
    output logic [DATA_WIDTH/8-1:0] lane_mask,
    output logic                    last_beat
);
    import axi4_slave_pkg::*;

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG2NB = $clog2(NB);

    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH:0]   incr;
    logic [LOG2NB-1:0]     offset;

    // One extra address bit so the increment past the final beat never wraps.
    assign incr      = (ADDR_WIDTH + 1)'(1) << size_q;
    assign offset    = cur_addr[LOG2NB-1:0];
    assign last_beat = (beat_cnt == len_q);

    always_ff @(posedge clk) begin
        if (load) begin
            cur_addr <= {1'b0, start_addr};
            beat_cnt <= 8'd0;
            len_q    <= len;
            size_q   <= size;
        end else if (step) begin
            cur_addr <= cur_addr + incr;
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_comb begin
        int lo;
        int hi;
        lane_mask = '0;
        lo = int'(offset);
        hi = lo + (int'(1) << size_q);
        for (int i = 0; i < NB; i++) begin
            if (i >= lo && i < hi) begin
                lane_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_write_slave.sv
// AXI4 write-channel front end: turns each INCR burst into registered word writes.
// Define AXI_WSTRB_EN to add a WSTRB port that further qualifies mem_be.
module axi4_write_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         ARESTN,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [7:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
`ifdef AXI_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
`endif
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [DATA_WIDTH/8-1:0]      mem_be
);
    import axi4_slave_pkg::*;

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG2NB = $clog2(NB);
    localparam int MAW    = $clog2(MEM_DEPTH);

    wstate_t             state_q, state_d;
    logic                awready_q, wready_q, bvalid_q;
    resp_t               bresp_q;
    logic                err_q, err_d;
    logic                load, beat;
    logic                mem_we_q;
    logic [MAW-1:0]      mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [NB-1:0]       mem_be_q;

    logic [ADDR_WIDTH:0] cur_addr;
    logic [NB-1:0]       lane_mask;
    logic [NB-1:0]       be_d;
    logic                last_beat;

    logic [31:0]         aw_addr32, aw_span, aw_last;
    logic                aw_err;

    axi4_burst_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .load       (load),
        .step       (beat),
        .start_addr (AWADDR),
        .len        (AWLEN),
        .size       (AWSIZE),
        .cur_addr   (cur_addr),
        .lane_mask  (lane_mask),
        .last_beat  (last_beat)
    );

    // Burst legality is decided once, at the AW handshake, from the raw request.
    always_comb begin
        aw_addr32 = 32'(AWADDR);
        aw_span   = (32'(AWLEN) + 32'd1) << AWSIZE;
        aw_last   = aw_addr32 + (32'(AWLEN) << AWSIZE);
        aw_err    = 1'b0;
        if (AWSIZE > 3'(LOG2NB)) begin
            aw_err = 1'b1;
        end
        if ((aw_addr32 & ((32'd1 << AWSIZE) - 32'd1)) != 32'd0) begin
            aw_err = 1'b1;
        end
        if ((aw_addr32 & 32'hFFF) + aw_span > 32'(BOUNDARY_4K)) begin
            aw_err = 1'b1;
        end
        if ((aw_last >> LOG2NB) >= 32'(MEM_DEPTH)) begin
            aw_err = 1'b1;
        end
    end

`ifdef AXI_WSTRB_EN
    assign be_d = lane_mask & WSTRB;
`else
    assign be_d = lane_mask;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load    = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (AWVALID && awready_q) begin
                    load    = 1'b1;
                    err_d   = aw_err;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (WVALID && wready_q) begin
                    beat = 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                        if (!WLAST) begin
                            err_d = 1'b1;
                        end
                    end else if (WLAST) begin
                        // Master ended the burst early: stop taking data.
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bvalid_q && BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they track the FSM edge-for-edge.
    always_ff @(posedge clk) begin
        if (!ARESTN) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= (state_d == IDLE);
            wready_q  <= (state_d == DATA);
            bvalid_q  <= (state_d == RESP);
            bresp_q   <= (state_d == RESP && err_d) ? SLVERR : OKAY;
            err_q     <= err_d;
            // err_q is the burst's own error; a late WLAST error does not suppress this beat.
            mem_we_q  <= beat && !err_q;
            if (beat) begin
                mem_addr_q  <= MAW'(cur_addr >> LOG2NB);
                mem_wdata_q <= WDATA;
                mem_be_q    <= be_d;
            end
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_axi4_write_slave.sv
// Directed bench for axi4_write_slave (default build, no WSTRB port).
module tb_axi4_write_slave;

    logic        clk = 1'b0;
    logic        ARESTN;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];

    always #5 clk = ~clk;

    axi4_write_slave dut (
        .clk       (clk),
        .ARESTN    (ARESTN),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wb_q.push_back(mem_be);
        end
    end

    always @(negedge clk) begin
        if (ARESTN === 1'b1) begin
            total++;
            assert (!(AWREADY === 1'b1 && WREADY === 1'b1)) else begin
                bad++;
                $error("FAIL ready_excl observed=AWREADY%b/WREADY%b expected=not both high", AWREADY, WREADY);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wb_q.delete();
    endtask

    task automatic check_write(input int idx, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        if (idx < wa_q.size()) begin
            check($sformatf("wr%0d_addr", idx), 64'(wa_q[idx]), 64'(a));
            check($sformatf("wr%0d_data", idx), 64'(wd_q[idx]), 64'(d));
            check($sformatf("wr%0d_be", idx), 64'(wb_q[idx]), 64'(be));
        end else begin
            check($sformatf("wr%0d_present", idx), 64'(wa_q.size()), 64'(idx + 1));
        end
    endtask

    // Tasks are entered and return just after a falling edge.
    task automatic aw_send(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size);
        logic ok;
        ok      = 1'b0;
        AWADDR  = a;
        AWLEN   = len;
        AWSIZE  = size;
        AWVALID = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (AWREADY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("aw_handshake", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic last);
        logic ok;
        ok     = 1'b0;
        WDATA  = d;
        WLAST  = last;
        WVALID = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (WREADY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("w_handshake", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_take(input int hold, input logic [1:0] exp_resp);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (BVALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bvalid_up", 64'(ok), 64'd1);
        check("bresp", 64'(BRESP), 64'(exp_resp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bvalid_hold", 64'(BVALID), 64'd1);
            check("bresp_hold", 64'(BRESP), 64'(exp_resp));
        end
        BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        BREADY = 1'b0;
        check("bvalid_clear", 64'(BVALID), 64'd0);
        check("awready_back", 64'(AWREADY), 64'd1);
    endtask

    initial begin
        ARESTN  = 1'b0;
        AWADDR  = 16'h0;
        AWLEN   = 8'd0;
        AWSIZE  = 3'd0;
        AWVALID = 1'b1;
        WDATA   = 32'h0;
        WLAST   = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;

        // Reset held 3 cycles with AWVALID asserted.
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready", 64'(WREADY), 64'd0);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_bresp", 64'(BRESP), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        AWVALID = 1'b0;
        ARESTN  = 1'b1;
        @(negedge clk);
        check("rel_awready", 64'(AWREADY), 64'd1);
        check("rel_wready", 64'(WREADY), 64'd0);
        check("rel_writes", 64'(wa_q.size()), 64'd0);

        // Aligned 4-beat word burst with WVALID gaps.
        clear_log();
        aw_send(16'h0010, 8'd3, 3'd2);
        check("aw_drop", 64'(AWREADY), 64'd0);
        w_send(32'hA0A0_0000, 1'b0);
        @(negedge clk);
        w_send(32'hA1A1_1111, 1'b0);
        @(negedge clk);
        w_send(32'hA2A2_2222, 1'b0);
        @(negedge clk);
        w_send(32'hA3A3_3333, 1'b1);
        check("wready_drop", 64'(WREADY), 64'd0);
        b_take(3, 2'b00);
        check("b1_nwr", 64'(wa_q.size()), 64'd4);
        check_write(0, 10'd4, 32'hA0A0_0000, 4'hF);
        check_write(1, 10'd5, 32'hA1A1_1111, 4'hF);
        check_write(2, 10'd6, 32'hA2A2_2222, 4'hF);
        check_write(3, 10'd7, 32'hA3A3_3333, 4'hF);

        // 4KB crossing: beats accepted, nothing written, SLVERR.
        clear_log();
        aw_send(16'h0FF8, 8'd3, 3'd2);
        w_send(32'hB0, 1'b0);
        w_send(32'hB1, 1'b0);
        w_send(32'hB2, 1'b0);
        w_send(32'hB3, 1'b1);
        b_take(0, 2'b10);
        check("b2_nwr", 64'(wa_q.size()), 64'd0);

        // Byte beats inside one word.
        clear_log();
        aw_send(16'h0002, 8'd1, 3'd0);
        w_send(32'h1122_3344, 1'b0);
        w_send(32'h5566_7788, 1'b1);
        b_take(1, 2'b00);
        check("b3_nwr", 64'(wa_q.size()), 64'd2);
        check_write(0, 10'd0, 32'h1122_3344, 4'b0100);
        check_write(1, 10'd0, 32'h5566_7788, 4'b1000);

        // Early WLAST on beat 1 of a 4-beat burst.
        clear_log();
        aw_send(16'h0020, 8'd3, 3'd2);
        w_send(32'hC0, 1'b0);
        w_send(32'hC1, 1'b1);
        check("early_wready", 64'(WREADY), 64'd0);
        b_take(0, 2'b10);
        check("b4_nwr", 64'(wa_q.size()), 64'd2);
        check_write(0, 10'd8, 32'hC0, 4'hF);
        check_write(1, 10'd9, 32'hC1, 4'hF);

        // Missing WLAST on the final beat.
        clear_log();
        aw_send(16'h0040, 8'd1, 3'd2);
        w_send(32'hD0, 1'b0);
        w_send(32'hD1, 1'b0);
        b_take(0, 2'b10);
        check("b5_nwr", 64'(wa_q.size()), 64'd2);
        check_write(1, 10'd17, 32'hD1, 4'hF);

        // Reset mid-burst after beat 1 of an 8-beat burst.
        clear_log();
        aw_send(16'h0080, 8'd7, 3'd2);
        w_send(32'hE0, 1'b0);
        w_send(32'hE1, 1'b0);
        ARESTN = 1'b0;
        WVALID = 1'b1;
        WDATA  = 32'hEEEE_EEEE;
        repeat (3) @(negedge clk);
        check("mid_rst_writes", 64'(wa_q.size()), 64'd2);
        check("mid_rst_mem_we", 64'(mem_we), 64'd0);
        ARESTN = 1'b1;
        repeat (4) @(negedge clk);
        WVALID = 1'b0;
        check("post_rst_writes", 64'(wa_q.size()), 64'd2);
        check("post_rst_bvalid", 64'(BVALID), 64'd0);
        check("post_rst_awready", 64'(AWREADY), 64'd1);
        clear_log();
        aw_send(16'h0100, 8'd0, 3'd2);
        w_send(32'hF00D_CAFE, 1'b1);
        b_take(0, 2'b00);
        check("b6_nwr", 64'(wa_q.size()), 64'd1);
        check_write(0, 10'd64, 32'hF00D_CAFE, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_write_slave.md
Name: axi4_write_slave

Overview:
- Write-channel front end of the AXI4 memory-mapped slave. It accepts AW/W/B handshakes from the write master and converts each INCR burst into one registered word-write per beat on a simple memory port.
- Sits directly downstream of the AXI write driver and directly upstream of the slave memory array.
- Only INCR bursts are supported; there is no AWBURST input.

Parameters:
- DATA_WIDTH, 32, WDATA/mem_wdata width in bits; must be 32 or 64.
- ADDR_WIDTH, 16, AWADDR width in bits (byte address).
- MEM_DEPTH, 1024, number of DATA_WIDTH words in the downstream memory.

Ports:
- clk  in  1  clock; all logic on rising edge.
- ARESTN  in  1  synchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  burst start byte address.
- AWLEN  in  8  beats minus one.
- AWSIZE  in  3  bytes per beat = 1<<AWSIZE.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  DATA_WIDTH  write data.
- WLAST  in  1  last beat marker.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  $clog2(MEM_DEPTH)  word address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_be  out  DATA_WIDTH/8  byte enables.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on ARESTN.
- Reset values while ARESTN=0 at a clk edge: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. The FSM goes to IDLE.
- Reset mid-burst: the burst is abandoned, no further mem_we, and no B response is issued.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1 starting the first cycle after reset is released.
  - On AWVALID&&AWREADY: latch AWADDR/AWLEN/AWSIZE, clear beat_cnt, compute err, go to DATA.
  - AWREADY drops in the same edge.
- err is set if any of the following holds:
  - AWSIZE > $clog2(DATA_WIDTH/8);
  - AWADDR is not aligned to 1<<AWSIZE;
  - AWADDR[11:0] + ((AWLEN+1)<<AWSIZE) > 4096 (4KB crossing);
  - the last beat's word address >= MEM_DEPTH.
- DATA:
  - WREADY=1. Each WVALID&&WREADY is one beat; WVALID gaps between beats are legal.
  - Beat effect when err=0: next cycle mem_we=1, mem_addr=cur_addr>>$clog2(DATA_WIDTH/8), mem_wdata=WDATA, mem_be = lane mask of (1<<AWSIZE) bytes at cur_addr modulo DATA_WIDTH/8. Write latency is one cycle.
  - Beat effect when err=1: the beat is accepted and mem_we stays 0.
  - After each beat: cur_addr += 1<<AWSIZE, computed in ADDR_WIDTH+1 bits (no wrap is possible once the 4KB check has passed), and beat_cnt++.
- Burst termination:
  - The burst ends on the beat where beat_cnt==AWLEN. WREADY drops in the same edge; go to RESP.
  - WLAST=1 on an earlier beat: set err for the response, accept no further data, go to RESP.
  - WLAST=0 on the final beat: set err.
  - A beat write already issued is not revoked.
- RESP:
  - BVALID=1, BRESP = err ? 10 : 00.
  - Hold BVALID and BRESP stable until BREADY. On BVALID&&BREADY, clear BVALID and return to IDLE.
  - AWREADY re-asserts the cycle after B completes. There is one outstanding burst only.
- AWREADY and WREADY are never high in the same cycle.
- AW arriving during DATA or RESP is ignored until IDLE.

Optional Feature:
- Macro: AXI_WSTRB_EN.
- Defined: adds input port WSTRB (DATA_WIDTH/8). mem_be = lane mask & WSTRB. A beat with mem_be==0 still pulses mem_we.
- Undefined: no WSTRB port; mem_be = lane mask only.

Decomposition:
- Package axi4_slave_pkg:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10);
  - wstate_t enum (IDLE, DATA, RESP);
  - localparam BOUNDARY_4K=4096.
- Sub-module axi4_burst_addr_gen:
  - holds cur_addr and beat_cnt;
  - computes the next address, lane mask, and last-beat flag from the latched AWADDR/AWLEN/AWSIZE.

Test Plan:
- Reset with ARESTN=0 for 3 cycles while AWVALID=1 -> all outputs 0, no AW accepted; AWREADY=1 the cycle after release.
- AWADDR=0x0010, AWLEN=3, AWSIZE=2, WDATA=A0..A3 with a 1-cycle WVALID gap between beats -> mem_we pulses at word addresses 4,5,6,7 with matching data and mem_be=4'hF; BRESP=00; BVALID held 3 cycles until BREADY rises.
- AWADDR=0x0FF8, AWLEN=3, AWSIZE=2 (crosses 4KB) -> all 4 beats accepted, mem_we never asserted, BRESP=10.
- AWADDR=0x0002, AWLEN=1, AWSIZE=0 -> mem_be=4'b0100 then 4'b1000, both at mem_addr 0; BRESP=00.
- AWLEN=3 with WLAST on beat 1 -> WREADY drops after beat 1, 2 mem writes, BRESP=10. Separately, AWLEN=1 with WLAST=0 on the final beat -> BRESP=10.
- ARESTN low in DATA after beat 1 of an AWLEN=7 burst -> no further mem_we, BVALID stays 0; a new burst then completes with BRESP=00.
